axi_sram_slave: RTL and testbench

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_sram_slave.sv | 183 ++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// AXI3-style single-port SRAM slave: one transaction in flight, INCR bursts of
// 32-bit words, read data taken from a synchronous SRAM with one-cycle latency.
module axi_sram_slave #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              axi_clk,
    input  logic              axi_rst,
    // read address channel
    input  logic [3:0]        ARID_S,
    input  logic [31:0]       ARADDR_S,
    input  logic [3:0]        ARLEN_S,
    input  logic              ARVALID_S,
    output logic              ARREADY_S,
    // read data channel
    output logic [3:0]        RID_S,
    output logic [31:0]       RDATA_S,
    output logic [1:0]        RRESP_S,
    output logic              RLAST_S,
    output logic              RVALID_S,
    input  logic              RREADY_S,
    // write address channel
    input  logic [3:0]        AWID_S,
    input  logic [31:0]       AWADDR_S,
    input  logic [3:0]        AWLEN_S,
    input  logic              AWVALID_S,
    output logic              AWREADY_S,
    // write data channel
    input  logic [31:0]       WDATA_S,
    input  logic [3:0]        WSTRB_S,
    input  logic              WLAST_S,
    input  logic              WVALID_S,
    output logic              WREADY_S,
    // write response channel
    output logic [3:0]        BID_S,
    output logic [1:0]        BRESP_S,
    output logic              BVALID_S,
    input  logic              BREADY_S,
    // SRAM port
    output logic              SRAM_CEB,
    output logic [3:0]        SRAM_WEB,
    output logic [ADDR_W-1:0] SRAM_A,
    output logic [31:0]       SRAM_DI,
    input  logic [31:0]       SRAM_DO
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_R_REQ  = 3'd1;
    localparam logic [2:0] S_R_RESP = 3'd2;
    localparam logic [2:0] S_W_DATA = 3'd3;
    localparam logic [2:0] S_B_RESP = 3'd4;

    logic [2:0]        r_state;
    logic [3:0]        r_id;
    logic [3:0]        r_len;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;

    logic w_last_beat;
    logic w_unused;

    assign w_last_beat = (r_cnt == r_len);

    // Byte-lane bits and bits above the SRAM word range are not decoded.
    assign w_unused = ^{ARADDR_S[31:ADDR_W+2], ARADDR_S[1:0],
                        AWADDR_S[31:ADDR_W+2], AWADDR_S[1:0]};

    // Latched ID/address stay visible on the outputs; everything else is per-state.
    assign RID_S   = r_id;
    assign BID_S   = r_id;
    assign RRESP_S = 2'b00;
    assign SRAM_A  = r_addr;

    // Channel handshakes and SRAM strobes decoded from the current state.
    always_comb begin
        ARREADY_S = 1'b0;
        AWREADY_S = 1'b0;
        RVALID_S  = 1'b0;
        RDATA_S   = '0;
        RLAST_S   = 1'b0;
        WREADY_S  = 1'b0;
        BVALID_S  = 1'b0;
        BRESP_S   = 2'b00;
        SRAM_CEB  = 1'b1;
        SRAM_WEB  = 4'hF;
        SRAM_DI   = '0;
        case (r_state)
            S_IDLE: begin
                ARREADY_S = 1'b1;
                AWREADY_S = ~ARVALID_S;
            end
            S_R_REQ: begin
                SRAM_CEB = 1'b0;
            end
            S_R_RESP: begin
                RVALID_S = 1'b1;
                RDATA_S  = SRAM_DO;
                RLAST_S  = w_last_beat;
            end
            S_W_DATA: begin
                WREADY_S = 1'b1;
                if (WVALID_S) begin
                    SRAM_CEB = 1'b0;
                    SRAM_WEB = ~WSTRB_S;
                    SRAM_DI  = WDATA_S;
                end
            end
            S_B_RESP: begin
                BVALID_S = 1'b1;
                BRESP_S  = r_err ? 2'b10 : 2'b00;
            end
            default: ;
        endcase
    end

    // Transaction sequencing, burst address/count tracking and WLAST checking.
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            r_state <= S_IDLE;
            r_id    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ARVALID_S) begin
                        r_id    <= ARID_S;
                        r_addr  <= ARADDR_S[ADDR_W+1:2];
                        r_len   <= ARLEN_S;
                        r_cnt   <= '0;
                        r_state <= S_R_REQ;
                    end else if (AWVALID_S) begin
                        r_id    <= AWID_S;
                        r_addr  <= AWADDR_S[ADDR_W+1:2];
                        r_len   <= AWLEN_S;
                        r_cnt   <= '0;
                        r_state <= S_W_DATA;
                    end
                end
                S_R_REQ: begin
                    r_state <= S_R_RESP;
                end
                S_R_RESP: begin
                    if (RREADY_S) begin
                        if (w_last_beat) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_cnt   <= r_cnt + 4'd1;
                            r_state <= S_R_REQ;
                        end
                    end
                end
                S_W_DATA: begin
                    if (WVALID_S) begin
                        // Burst length comes from AWLEN only; WLAST is just cross-checked.
                        if (WLAST_S != w_last_beat) begin
                            r_err <= 1'b1;
                        end
                        if (w_last_beat) begin
                            r_state <= S_B_RESP;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                            r_cnt  <= r_cnt + 4'd1;
                        end
                    end
                end
                S_B_RESP: begin
                    if (BREADY_S) begin
                        r_err   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed testbench for axi_sram_slave with a behavioural synchronous SRAM.
module tb_axi_sram_slave;

    localparam int unsigned AW = 14;

    logic          axi_clk = 1'b0;
    logic          axi_rst;
    logic [3:0]    ARID_S;
    logic [31:0]   ARADDR_S;
    logic [3:0]    ARLEN_S;
    logic          ARVALID_S;
    logic          ARREADY_S;
    logic [3:0]    RID_S;
    logic [31:0]   RDATA_S;
    logic [1:0]    RRESP_S;
    logic          RLAST_S;
    logic          RVALID_S;
    logic          RREADY_S;
    logic [3:0]    AWID_S;
    logic [31:0]   AWADDR_S;
    logic [3:0]    AWLEN_S;
    logic          AWVALID_S;
    logic          AWREADY_S;
    logic [31:0]   WDATA_S;
    logic [3:0]    WSTRB_S;
    logic          WLAST_S;
    logic          WVALID_S;
    logic          WREADY_S;
    logic [3:0]    BID_S;
    logic [1:0]    BRESP_S;
    logic          BVALID_S;
    logic          BREADY_S;
    logic          SRAM_CEB;
    logic [3:0]    SRAM_WEB;
    logic [AW-1:0] SRAM_A;
    logic [31:0]   SRAM_DI;
    logic [31:0]   SRAM_DO;

    int n_checks = 0;
    int n_errors = 0;

    axi_sram_slave #(.ADDR_W(AW)) dut (
        .axi_clk(axi_clk), .axi_rst(axi_rst),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
        .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
        .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S),
        .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S),
        .WVALID_S(WVALID_S), .WREADY_S(WREADY_S),
        .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S),
        .SRAM_CEB(SRAM_CEB), .SRAM_WEB(SRAM_WEB), .SRAM_A(SRAM_A),
        .SRAM_DI(SRAM_DI), .SRAM_DO(SRAM_DO)
    );

    always #5 axi_clk = ~axi_clk;

    // SRAM model: one-cycle read latency, output held until the next enable.
    logic [31:0]   mem [0:(1<<AW)-1];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_data;

    always @(posedge axi_clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (!SRAM_CEB) begin
            if (SRAM_WEB == 4'hF) begin
                SRAM_DO <= mem[SRAM_A];
            end else begin
                for (int k = 0; k < 4; k++)
                    if (!SRAM_WEB[k]) mem[SRAM_A][k*8 +: 8] <= SRAM_DI[k*8 +: 8];
            end
        end
    end

    // Result capture
    logic [31:0] rd_data [16];
    logic        rd_last [16];
    logic [3:0]  rd_id   [16];
    int          rd_lat  [16];
    logic [31:0] wr_data [16];
    logic        wr_ceb  [16];
    logic [3:0]  wr_web  [16];
    logic [AW-1:0] wr_a  [16];
    logic [31:0] wr_di   [16];
    int          aw_wait;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge axi_clk); #1;
        pl_en = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the last R handshake.
    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input int stall_beat, input int stall_cycles);
        int k;
        int lat;
        logic [31:0] hold_data;
        logic        hold_last;
        ARID_S = id; ARADDR_S = addr; ARLEN_S = len; ARVALID_S = 1'b1;
        RREADY_S = (stall_beat != 0);
        for (k = 0; k < 20; k++) begin
            @(negedge axi_clk);
            if (ARREADY_S) break;
            @(posedge axi_clk); #1;
        end
        if (k == 20) begin
            check("ar_ready_timeout", 32'(ARREADY_S), 32'd1);
            ARVALID_S = 1'b0;
            return;
        end
        @(posedge axi_clk); #1;
        ARVALID_S = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            RREADY_S = (b != stall_beat);
            lat = 0;
            for (k = 0; k < 20; k++) begin
                @(negedge axi_clk);
                lat++;
                if (RVALID_S) break;
                @(posedge axi_clk); #1;
            end
            if (k == 20) begin
                check("rvalid_timeout", 32'(RVALID_S), 32'd1);
                RREADY_S = 1'b0;
                return;
            end
            rd_lat[b] = lat;
            if (b == stall_beat) begin
                hold_data = RDATA_S;
                hold_last = RLAST_S;
                check("stall_ceb", 32'(SRAM_CEB), 32'd1);
                for (int s = 1; s < stall_cycles; s++) begin
                    @(posedge axi_clk); #1;
                    @(negedge axi_clk);
                    check("stall_rvalid", 32'(RVALID_S), 32'd1);
                    check("stall_rdata", RDATA_S, hold_data);
                    check("stall_rlast", 32'(RLAST_S), 32'(hold_last));
                    check("stall_ceb", 32'(SRAM_CEB), 32'd1);
                end
                @(posedge axi_clk); #1;
                RREADY_S = 1'b1;
                @(negedge axi_clk);
            end
            rd_data[b] = RDATA_S;
            rd_last[b] = RLAST_S;
            rd_id[b]   = RID_S;
            @(posedge axi_clk); #1;
        end
        RREADY_S = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the B handshake.
    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input int nbeats, input int last_idx, input logic [3:0] strb);
        int k;
        AWID_S = id; AWADDR_S = addr; AWLEN_S = len; AWVALID_S = 1'b1; BREADY_S = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge axi_clk);
            if (AWREADY_S) break;
            @(posedge axi_clk); #1;
        end
        aw_wait = k;
        if (k == 20) begin
            check("aw_ready_timeout", 32'(AWREADY_S), 32'd1);
            AWVALID_S = 1'b0;
            return;
        end
        @(posedge axi_clk); #1;
        AWVALID_S = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            WVALID_S = 1'b1; WDATA_S = wr_data[b]; WSTRB_S = strb; WLAST_S = (b == last_idx);
            for (k = 0; k < 20; k++) begin
                @(negedge axi_clk);
                if (WREADY_S) break;
                @(posedge axi_clk); #1;
            end
            if (k == 20) begin
                check("wready_timeout", 32'(WREADY_S), 32'd1);
                WVALID_S = 1'b0;
                return;
            end
            wr_ceb[b] = SRAM_CEB; wr_web[b] = SRAM_WEB; wr_a[b] = SRAM_A; wr_di[b] = SRAM_DI;
            @(posedge axi_clk); #1;
        end
        WVALID_S = 1'b0; WLAST_S = 1'b0; BREADY_S = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(negedge axi_clk);
            if (BVALID_S) break;
            @(posedge axi_clk); #1;
        end
        if (k == 20) check("bvalid_timeout", 32'(BVALID_S), 32'd1);
        b_id = BID_S; b_resp = BRESP_S;
        @(posedge axi_clk); #1;
        BREADY_S = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        axi_rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        ARID_S = '0; ARADDR_S = '0; ARLEN_S = '0; ARVALID_S = 1'b0; RREADY_S = 1'b0;
        AWID_S = '0; AWADDR_S = '0; AWLEN_S = '0; AWVALID_S = 1'b0;
        WDATA_S = '0; WSTRB_S = '0; WLAST_S = 1'b0; WVALID_S = 1'b0; BREADY_S = 1'b0;

        // Reset state
        repeat (3) @(posedge axi_clk);
        #1;
        @(negedge axi_clk);
        check("rst_arready", 32'(ARREADY_S), 32'd1);
        check("rst_awready", 32'(AWREADY_S), 32'd1);
        check("rst_rvalid",  32'(RVALID_S),  32'd0);
        check("rst_wready",  32'(WREADY_S),  32'd0);
        check("rst_bvalid",  32'(BVALID_S),  32'd0);
        check("rst_ceb",     32'(SRAM_CEB),  32'd1);
        check("rst_web",     32'(SRAM_WEB),  32'hF);
        check("rst_a",       32'(SRAM_A),    32'd0);
        check("rst_rid",     32'(RID_S),     32'd0);
        @(posedge axi_clk); #1;
        axi_rst = 1'b0;

        preload(14'd4,     32'hDEADBEEF);
        preload(14'h3FFF,  32'h11112222);
        preload(14'h0000,  32'h33334444);
        preload(14'd8,     32'hFFFFFFFF);
        preload(14'h20,    32'hA0A0A0A0);
        preload(14'h21,    32'hA1A1A1A1);
        preload(14'h22,    32'hA2A2A2A2);
        preload(14'h23,    32'hA3A3A3A3);

        // Single-beat read, cycle-exact timing
        ARID_S = 4'd3; ARADDR_S = 32'h10; ARLEN_S = 4'd0; ARVALID_S = 1'b1; RREADY_S = 1'b0;
        @(negedge axi_clk);
        check("s_arready", 32'(ARREADY_S), 32'd1);
        @(posedge axi_clk); #1;
        ARVALID_S = 1'b0;
        @(negedge axi_clk);
        check("s_t1_ceb",    32'(SRAM_CEB), 32'd0);
        check("s_t1_web",    32'(SRAM_WEB), 32'hF);
        check("s_t1_a",      32'(SRAM_A),   32'd4);
        check("s_t1_rvalid", 32'(RVALID_S), 32'd0);
        @(posedge axi_clk); #1;
        @(negedge axi_clk);
        check("s_t2_rvalid", 32'(RVALID_S), 32'd1);
        check("s_t2_rdata",  RDATA_S,       32'hDEADBEEF);
        check("s_t2_rlast",  32'(RLAST_S),  32'd1);
        check("s_t2_rid",    32'(RID_S),    32'd3);
        check("s_t2_rresp",  32'(RRESP_S),  32'd0);
        check("s_t2_ceb",    32'(SRAM_CEB), 32'd1);
        RREADY_S = 1'b1;
        @(posedge axi_clk); #1;
        RREADY_S = 1'b0;
        @(negedge axi_clk);
        check("s_done_rvalid",  32'(RVALID_S),  32'd0);
        check("s_done_arready", 32'(ARREADY_S), 32'd1);
        @(posedge axi_clk); #1;

        // 4-beat write burst
        for (int b = 0; b < 4; b++) wr_data[b] = 32'h5A5A0000 + b;
        axi_write(4'd5, 32'h100, 4'd3, 4, 3, 4'hF);
        for (int b = 0; b < 4; b++) begin
            check("wb_ceb", 32'(wr_ceb[b]), 32'd0);
            check("wb_web", 32'(wr_web[b]), 32'h0);
            check("wb_a",   32'(wr_a[b]),   32'h40 + b);
            check("wb_di",  wr_di[b],       32'h5A5A0000 + b);
            check("wb_mem", mem[14'h40 + b], 32'h5A5A0000 + b);
        end
        check("wb_bid",   32'(b_id),   32'd5);
        check("wb_bresp", 32'(b_resp), 32'd0);

        // Partial strobe write; address bits outside the word index ignored
        wr_data[0] = 32'h12345678;
        axi_write(4'd1, 32'hABCD0023, 4'd0, 1, 0, 4'b0011);
        check("ps_web",   32'(wr_web[0]), 32'hC);
        check("ps_a",     32'(wr_a[0]),   32'd8);
        check("ps_mem",   mem[8],         32'hFFFF5678);
        check("ps_bresp", 32'(b_resp),    32'd0);
        axi_read(4'd1, 32'h20, 4'd0, -1, 0);
        check("ps_rdata", rd_data[0], 32'hFFFF5678);

        // Read burst with RREADY held low five cycles on the second beat
        axi_read(4'd7, 32'h80, 4'd3, 1, 5);
        check("st_d0", rd_data[0], 32'hA0A0A0A0);
        check("st_d1", rd_data[1], 32'hA1A1A1A1);
        check("st_d2", rd_data[2], 32'hA2A2A2A2);
        check("st_d3", rd_data[3], 32'hA3A3A3A3);
        check("st_l1", 32'(rd_last[1]), 32'd0);
        check("st_l2", 32'(rd_last[2]), 32'd0);
        check("st_l3", 32'(rd_last[3]), 32'd1);
        check("st_id", 32'(rd_id[3]),   32'd7);
        check("st_lat0", 32'(rd_lat[0]), 32'd2);
        check("st_lat2", 32'(rd_lat[2]), 32'd2);
        check("st_lat3", 32'(rd_lat[3]), 32'd2);

        // Address wrap at top of SRAM
        axi_read(4'd2, 32'h1234FFFC, 4'd1, -1, 0);
        check("wr_d0", rd_data[0], 32'h11112222);
        check("wr_d1", rd_data[1], 32'h33334444);
        check("wr_l0", 32'(rd_last[0]), 32'd0);
        check("wr_l1", 32'(rd_last[1]), 32'd1);

        // AR and AW together: read wins, AW waits until read completes
        ARID_S = 4'd9; ARADDR_S = 32'h10; ARLEN_S = 4'd0; ARVALID_S = 1'b1;
        AWID_S = 4'd6; AWADDR_S = 32'h200; AWLEN_S = 4'd0; AWVALID_S = 1'b1;
        @(negedge axi_clk);
        check("tie_arready", 32'(ARREADY_S), 32'd1);
        check("tie_awready", 32'(AWREADY_S), 32'd0);
        @(posedge axi_clk); #1;
        ARVALID_S = 1'b0; RREADY_S = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(negedge axi_clk);
            check("tie_awready_busy", 32'(AWREADY_S), 32'd0);
            if (RVALID_S && RLAST_S) break;
            @(posedge axi_clk); #1;
        end
        if (k == 20) check("tie_rlast_timeout", 32'(RLAST_S), 32'd1);
        check("tie_rdata", RDATA_S, 32'hDEADBEEF);
        check("tie_rid",   32'(RID_S), 32'd9);
        @(posedge axi_clk); #1;
        RREADY_S = 1'b0;
        wr_data[0] = 32'hCAFEF00D;
        axi_write(4'd6, 32'h200, 4'd0, 1, 0, 4'hF);
        check("tie_aw_wait", 32'(aw_wait), 32'd0);
        check("tie_mem",     mem[14'h80],  32'hCAFEF00D);
        check("tie_bid",     32'(b_id),    32'd6);

        // Early WLAST: length still from AWLEN, error response
        for (int b = 0; b < 3; b++) wr_data[b] = 32'hC0DE0000 + b;
        axi_write(4'd4, 32'h300, 4'd2, 3, 0, 4'hF);
        check("el_mem0",  mem[14'hC0], 32'hC0DE0000);
        check("el_mem1",  mem[14'hC1], 32'hC0DE0001);
        check("el_mem2",  mem[14'hC2], 32'hC0DE0002);
        check("el_bresp", 32'(b_resp), 32'd2);
        check("el_bid",   32'(b_id),   32'd4);
        wr_data[0] = 32'h0BADF00D;
        axi_write(4'd4, 32'h304, 4'd0, 1, 0, 4'hF);
        check("el_clr_bresp", 32'(b_resp), 32'd0);

        // Reset in the middle of a read burst
        ARID_S = 4'd8; ARADDR_S = 32'h80; ARLEN_S = 4'd3; ARVALID_S = 1'b1; RREADY_S = 1'b0;
        @(posedge axi_clk); #1;
        ARVALID_S = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge axi_clk);
            if (RVALID_S) break;
            @(posedge axi_clk); #1;
        end
        if (k == 20) check("mr_rvalid_timeout", 32'(RVALID_S), 32'd1);
        @(posedge axi_clk); #1;
        axi_rst = 1'b1;
        @(posedge axi_clk); #1;
        @(negedge axi_clk);
        check("mr_rvalid",  32'(RVALID_S),  32'd0);
        check("mr_rlast",   32'(RLAST_S),   32'd0);
        check("mr_rid",     32'(RID_S),     32'd0);
        check("mr_arready", 32'(ARREADY_S), 32'd1);
        check("mr_ceb",     32'(SRAM_CEB),  32'd1);
        check("mr_a",       32'(SRAM_A),    32'd0);
        @(posedge axi_clk); #1;
        axi_rst = 1'b0;
        axi_read(4'd3, 32'h10, 4'd0, -1, 0);
        check("mr_after_rdata", rd_data[0], 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
